// File: rtl/mtr_counter_bank_if.sv
// Register bus and interrupt handshake for mtr_counter_bank.
//   WR/RD         one-cycle write/read strobes
//   SEL[5:0]      [5:4] type (00 cnt low, 01 cnt high, 10 cnt ctl, 11 global), [2:0] index
//   WR_DATA[17:0] write data
//   RD_DATA[17:0] registered read data
//   INTERRUPT_REQ any enabled source pending
//   INT_SEL[3:0]  selected source (8 = interval, 0..NCNT-1 = counter)
//   INT_ACK       one-cycle acknowledge of the source on INT_SEL
interface mtr_counter_bank_if;
   logic        WR;
   logic        RD;
   logic [5:0]  SEL;
   logic [17:0] WR_DATA;
   logic [17:0] RD_DATA;
   logic        INTERRUPT_REQ;
   logic [3:0]  INT_SEL;
   logic        INT_ACK;

   modport master (
      output WR, RD, SEL, WR_DATA, INT_ACK,
      input  RD_DATA, INTERRUPT_REQ, INT_SEL
   );

   modport slave (
      input  WR, RD, SEL, WR_DATA, INT_ACK,
      output RD_DATA, INTERRUPT_REQ, INT_SEL
   );
endinterface

// File: rtl/mtr_counter_bank.sv
// Bank of NCNT event counters plus a TICK_1MHZ interval timer, with a
// register interface and a prioritised interrupt request.
//   MBOX_CLK   system clock, rising edge
//   RESET      asynchronous, active-high reset
//   TICK_1MHZ  one-cycle pulse per microsecond, advances the interval count
//   CNT_EVENT  per-counter event inputs (edge or duration counted)
//   bus        register bus and interrupt handshake (slave side)
module mtr_counter_bank #(
   parameter int NCNT = 4,
   parameter int W    = 24,
   parameter int PW   = 12
) (
   input  logic            MBOX_CLK,
   input  logic            RESET,
   input  logic            TICK_1MHZ,
   input  logic [NCNT-1:0] CNT_EVENT,
   mtr_counter_bank_if.slave bus
);

   logic [1:0]      typ;
   logic [2:0]      idx;

   logic [W-1:0]    cnt    [NCNT];
   logic [17:0]     shadow [NCNT];
   logic [17:0]     cnt_lo [NCNT];
   logic [17:0]     cnt_hi [NCNT];
   logic [NCNT-1:0] en, dur, ie, ovf, evt_q;
   logic [NCNT-1:0] ctl_wr, clr, inc, ovf_set, ovf_clr, shadow_ld;

   logic            on_q, iie_q, done_q, ovr_q;
   logic [PW-1:0]   period, icnt;
   logic            wr_g0, wr_g1, icnt_zero, step, match;
   logic            done_set, ovr_set, clr_done, ack_ok, ack_done;

   logic [17:0]     rd_mux, rd_data_q;
   logic            req_nxt, int_req_q;
   logic [3:0]      sel_nxt, int_sel_q;
   logic            unused_bits;

   assign typ = bus.SEL[5:4];
   assign idx = bus.SEL[2:0];
   assign unused_bits = ^{bus.SEL[3], bus.WR_DATA};

   // An acknowledge only acts while a request is actually being presented.
   assign ack_ok   = bus.INT_ACK & int_req_q;
   assign ack_done = ack_ok & (int_sel_q == 4'd8);

   // Counter decode
   always_comb begin
      ctl_wr    = '0;
      clr       = '0;
      inc       = '0;
      ovf_set   = '0;
      ovf_clr   = '0;
      shadow_ld = '0;
      for (int unsigned k = 0; k < NCNT; k++) begin
         cnt_lo[k] = '0;
         cnt_hi[k] = '0;
         {cnt_hi[k], cnt_lo[k]} = 36'(cnt[k]);
         ctl_wr[k]    = bus.WR & (typ == 2'b10) & (idx == 3'(k));
         clr[k]       = (bus.WR & ~typ[1] & (idx == 3'(k))) | (ctl_wr[k] & bus.WR_DATA[3]);
         inc[k]       = en[k] & CNT_EVENT[k] & (dur[k] | ~evt_q[k]);
         ovf_set[k]   = inc[k] & ~clr[k] & (cnt[k] == '1);
         ovf_clr[k]   = (ctl_wr[k] & bus.WR_DATA[4]) | (ack_ok & (int_sel_q == 4'(k)));
         shadow_ld[k] = bus.RD & (typ == 2'b00) & (idx == 3'(k));
      end
   end

   always_ff @(posedge MBOX_CLK or posedge RESET) begin
      if (RESET) begin
         for (int unsigned k = 0; k < NCNT; k++) begin
            cnt[k]    <= '0;
            shadow[k] <= '0;
         end
         en    <= '0;
         dur   <= '0;
         ie    <= '0;
         ovf   <= '0;
         evt_q <= '0;
      end else begin
         evt_q <= CNT_EVENT;
         // A set in the same cycle wins over any clear.
         ovf   <= ovf_set | (ovf & ~ovf_clr);
         for (int unsigned k = 0; k < NCNT; k++) begin
            if (clr[k])
               cnt[k] <= '0;
            else if (inc[k])
               cnt[k] <= cnt[k] + W'(1);
            if (shadow_ld[k])
               shadow[k] <= cnt_hi[k];
            if (ctl_wr[k]) begin
               en[k]  <= bus.WR_DATA[0];
               dur[k] <= bus.WR_DATA[1];
               ie[k]  <= bus.WR_DATA[2];
            end
         end
      end
   end

   // Interval timer decode
   assign wr_g0     = bus.WR & (typ == 2'b11) & (idx == 3'd0);
   assign wr_g1     = bus.WR & (typ == 2'b11) & (idx == 3'd1);
   assign icnt_zero = (wr_g0 & bus.WR_DATA[2]) | wr_g1;
   assign clr_done  = wr_g0 & bus.WR_DATA[3];
   assign step      = on_q & TICK_1MHZ & ~icnt_zero;
   assign match     = (period != '0) & (icnt == period - PW'(1));
   assign done_set  = step & match;
   assign ovr_set   = step & ((match & done_q) | ((period == '0) & (icnt == '1)));

   always_ff @(posedge MBOX_CLK or posedge RESET) begin
      if (RESET) begin
         on_q   <= 1'b0;
         iie_q  <= 1'b0;
         done_q <= 1'b0;
         ovr_q  <= 1'b0;
         period <= '0;
         icnt   <= '0;
      end else begin
         if (wr_g0) begin
            on_q  <= bus.WR_DATA[0];
            iie_q <= bus.WR_DATA[1];
         end
         if (wr_g1)
            period <= bus.WR_DATA[PW-1:0];
         // With PERIOD == 0 match stays low and the increment wraps on its own.
         if (icnt_zero)
            icnt <= '0;
         else if (step)
            icnt <= match ? '0 : icnt + PW'(1);
         done_q <= done_set | (done_q & ~(clr_done | ack_done));
         ovr_q  <= ovr_set | (ovr_q & ~clr_done);
      end
   end

   // Read mux (pre-write state)
   always_comb begin
      rd_mux = '0;
      case (typ)
         2'b00: for (int unsigned k = 0; k < NCNT; k++)
                   if (idx == 3'(k)) rd_mux = cnt_lo[k];
         2'b01: for (int unsigned k = 0; k < NCNT; k++)
                   if (idx == 3'(k)) rd_mux = shadow[k];
         2'b10: for (int unsigned k = 0; k < NCNT; k++)
                   if (idx == 3'(k)) rd_mux = {13'd0, ovf[k], 1'b0, ie[k], dur[k], en[k]};
         default: begin
            case (idx)
               3'd0: rd_mux = {12'd0, ovr_q, done_q, 2'b00, iie_q, on_q};
               3'd1: rd_mux = 18'(period);
               3'd2: rd_mux = 18'(icnt);
               3'd3: begin
                  rd_mux[NCNT-1:0] = ovf;
                  rd_mux[8]        = done_q;
               end
               default: rd_mux = '0;
            endcase
         end
      endcase
   end

   // Interrupt priority: interval first, then lowest counter index
   always_comb begin
      req_nxt = 1'b0;
      sel_nxt = '0;
      if (done_q & iie_q) begin
         req_nxt = 1'b1;
         sel_nxt = 4'd8;
      end else begin
         for (int unsigned k = 0; k < NCNT; k++) begin
            if (!req_nxt && ovf[k] && ie[k]) begin
               req_nxt = 1'b1;
               sel_nxt = 4'(k);
            end
         end
      end
   end

   always_ff @(posedge MBOX_CLK or posedge RESET) begin
      if (RESET) begin
         rd_data_q <= '0;
         int_req_q <= 1'b0;
         int_sel_q <= '0;
      end else begin
         if (bus.RD)
            rd_data_q <= rd_mux;
         int_req_q <= req_nxt;
         int_sel_q <= sel_nxt;
      end
   end

   assign bus.RD_DATA       = rd_data_q;
   assign bus.INTERRUPT_REQ = int_req_q;
   assign bus.INT_SEL       = int_sel_q;

endmodule

// File: doc/mtr_counter_bank.md
MTR_COUNTER_BANK -- requirements
Module: mtr_counter_bank

Interface
REQ-001 Parameter NCNT, default 4, number of event counters (1..8).
REQ-002 Parameter W, default 24, counter width in bits (1..36).
REQ-003 Parameter PW, default 12, interval period width in bits (1..18).
REQ-004 MBOX_CLK  in  1  system clock; all state changes on its rising edge.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 TICK_1MHZ  in  1  one-cycle pulse, once per microsecond.
REQ-007 CNT_EVENT  in  NCNT  per-counter event inputs, synchronous to MBOX_CLK.
REQ-008 WR  in  1  register write strobe, one cycle.
REQ-009 RD  in  1  register read strobe, one cycle.
REQ-010 SEL  in  6  register select: [5:4] type (00 cnt low, 01 cnt high, 10 cnt ctl, 11 global), [2:0] index.
REQ-011 WR_DATA  in  18  write data, bit 0 = LSB.
REQ-012 RD_DATA  out  18  registered read data.
REQ-013 INTERRUPT_REQ  out  1  any enabled source pending.
REQ-014 INT_SEL  out  4  selected source: 8 = interval, 0..NCNT-1 = counter.
REQ-015 INT_ACK  in  1  one-cycle acknowledge, clears flag of source on INT_SEL.

Function
REQ-016 Counter ctl bits: [0] EN, [1] DUR, [2] IE, [3] CLR (write-only, self-clearing), [4] CLR_OVF (write-only); read returns EN, DUR, IE, 0, OVF in bits 0..4.
REQ-017 EN=1, DUR=0: counter increments once per 0->1 transition of CNT_EVENT[k] (previous value registered).
REQ-018 EN=1, DUR=1: counter increments every cycle CNT_EVENT[k] is high.
REQ-019 Counter wraps from 2^W-1 to 0 and sets sticky OVF[k] that cycle.
REQ-020 CLR, or a write to cnt low/high, zeroes the counter; CLR/write wins over a same-cycle increment; no OVF is set that cycle.
REQ-021 Write to cnt low/high zeroes the counter; counters are not preloadable.
REQ-022 Read cnt low returns bits [17:0] and, same cycle, latches bits [W-1:18] into shadow k; read cnt high returns shadow k, zero-extended; for W<=18 high reads 0.
REQ-023 Global index 0 (interval ctl): [0] ON, [1] IE, [2] RST_CNT (self-clearing), [3] CLR_DONE (clears DONE and OVRFLO); read returns ON, IE, 0, 0, DONE, OVRFLO.
REQ-024 Global index 1: PERIOD, PW bits, read/write; a write also zeroes the interval count.
REQ-025 Global index 2: interval count, read-only, PW bits; index 3: status, bit k = OVF[k], bit 8 = DONE.
REQ-026 ON=1: interval count increments on each TICK_1MHZ.
REQ-027 Tick with count == PERIOD-1: count -> 0, DONE <= 1; if DONE already 1, OVRFLO <= 1.
REQ-028 PERIOD == 0: timer never matches; count wraps at 2^PW and sets OVRFLO on wrap.
REQ-029 ON=0: count holds; RST_CNT zeroes it regardless of ON.
REQ-030 Pending sources: interval = DONE & IE; counter k = OVF[k] & IE[k].
REQ-031 INT_SEL priority: interval highest, then lowest counter index; INT_SEL = 0 when none pending.
REQ-032 INTERRUPT_REQ and INT_SEL registered, one cycle after the flag changes.
REQ-033 INT_ACK clears DONE (not OVRFLO) or OVF[INT_SEL]; a same-cycle set of that flag wins over the clear.
REQ-034 RD_DATA valid the cycle after RD and held until the next RD; unused bits and unmapped selects read 0; writes to unmapped selects are ignored.
REQ-035 Simultaneous RD and WR to one register: RD_DATA returns pre-write value.

Reset
REQ-036 RESET asynchronously clears all counters, shadows, ctl bits, OVF, DONE, OVRFLO, interval count and PERIOD.
REQ-037 During and after RESET: RD_DATA=0, INTERRUPT_REQ=0, INT_SEL=0; edge detectors cleared, so a CNT_EVENT high at reset release counts no edge.
REQ-038 RESET mid-operation aborts any read, latch or ACK in progress; no partial state survives.

Verification
REQ-039 Ctl0=EN, DUR=0; pulse CNT_EVENT[0] 5 times, 3 cycles each -> cnt0 low reads 5.
REQ-040 Ctl1=EN|DUR; hold CNT_EVENT[1] 10 cycles -> reads 10; W=24, preset via 2^24-1 increments -> wraps to 0, OVF[1]=1, IE=1 gives INTERRUPT_REQ=1, INT_SEL=1.
REQ-041 Counter at 0x7FFFF: read low -> 0x3FFFF; increment; read high -> 1 (shadow), not the new value.
REQ-042 PERIOD=3, ON|IE -> DONE after 3rd tick, INT_SEL=8; no ack, 3 more ticks -> OVRFLO=1; INT_ACK -> DONE=0, OVRFLO=1.
REQ-043 OVF[2] and DONE pending, both IE -> INT_SEL=8; ACK -> INT_SEL=2; ACK -> INTERRUPT_REQ=0.
REQ-044 Assert RESET while counter 0 counting and interval ON -> all reads 0, INTERRUPT_REQ=0 next cycle.
